intt_fsm: RTL and testbench

- Loop and control sequencer for the inverse NTT (INTT) of the 512-point mixed-radix transform.
- Counterpart of the forward-NTT controller. It accepts the same 4-bit conf command bus and drives the same index and strobe interface into the address generator, RAM banks and butterfly array.
- Traversal runs in the opposite direction to the forward transform: radix-4 stages first, with p ascending 0→3, then one final radix-2 stage.
- Also produces delayed write and enable strobes, and done flags for the top-level op sequencer.

---
 rtl/intt_pkg.sv | 61 ++++++
 rtl/intt_fsm_delay_line.sv | 30 +++
 rtl/intt_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_intt_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/intt_pkg.sv
// Shared constants, command codes and stage-shape helpers for the INTT controller.
package intt_pkg;

  // Command codes on the conf bus; any unlisted code decodes to CONF_IDLE.
  typedef enum logic [3:0] {
    CONF_IDLE        = 4'b0000,
    CONF_RADIX4      = 4'b0101,
    CONF_RADIX2      = 4'b0110,
    CONF_DONE_RADIX2 = 4'b0111,
    CONF_DONE_RADIX4 = 4'b1000
  } conf_e;

  localparam int N_BFLY      = 128;
  localparam int LOG2_N_BFLY = 7;
  localparam int CNT_W       = LOG2_N_BFLY;
  localparam int STAGE_W     = 3;

  // Stage numbers with special meaning.
  localparam logic [STAGE_W-1:0] P_FIRST_R4 = 3'd0;
  localparam logic [STAGE_W-1:0] P_LAST_R4  = 3'd3;
  localparam logic [STAGE_W-1:0] P_RADIX2   = 3'd4;

  // Completion codes reported to the op sequencer.
  localparam logic [2:0] DONE_NONE   = 3'b000;
  localparam logic [2:0] DONE_RADIX4 = 3'b011;
  localparam logic [2:0] DONE_RADIX2 = 3'b100;

  // Map a raw conf code onto the command enum, folding illegal codes to idle.
  function automatic conf_e decode_conf(input logic [3:0] code);
    case (code)
      4'b0101: return CONF_RADIX4;
      4'b0110: return CONF_RADIX2;
      4'b0111: return CONF_DONE_RADIX2;
      4'b1000: return CONF_DONE_RADIX4;
      default: return CONF_IDLE;
    endcase
  endfunction

  // Last intra-group index j of a radix-4 stage: (1 << 2p) - 1.
  function automatic logic [CNT_W-1:0] j_last(input logic [STAGE_W-1:0] stage);
    case (stage)
      3'd0:    return 7'd0;
      3'd1:    return 7'd3;
      3'd2:    return 7'd15;
      3'd3:    return 7'd63;
      default: return 7'd63;
    endcase
  endfunction

  // Last group index k of a radix-4 stage: (N_BFLY >> 2p) - 1.
  function automatic logic [CNT_W-1:0] k_last(input logic [STAGE_W-1:0] stage);
    case (stage)
      3'd0:    return 7'd127;
      3'd1:    return 7'd31;
      3'd2:    return 7'd7;
      3'd3:    return 7'd1;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/intt_fsm_delay_line.sv
// Fixed-depth shift register used to time write-back and drain strobes.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift the input through DEPTH registers; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stages[s] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int s = 1; s < DEPTH; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/intt_fsm.sv
// Loop and strobe sequencer for the inverse 512-point mixed-radix NTT.
// Radix-4 stages run first with p ascending 0..3, followed by one radix-2
// stage (p=4). Index counters follow the registered command; read, enable and
// select strobes lag the command decode by one register, write enable lags it
// by one register plus the butterfly write-back latency of the selected path.
module intt_fsm
  import intt_pkg::*;
#(
  parameter int LAT_R2 = 8,
  parameter int LAT_R4 = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         conf,
  output logic               sel,
  output logic [CNT_W-1:0]   i,
  output logic [CNT_W-1:0]   k,
  output logic [CNT_W-1:0]   j,
  output logic [STAGE_W-1:0] p,
  output logic               ren,
  output logic               en,
  output logic               wen,
  output logic               scale,
  output logic [2:0]         done_flag
);

  conf_e              conf_state;
  conf_e              conf_in;
  logic [CNT_W-1:0]   i_next;
  logic [CNT_W-1:0]   j_next;
  logic [CNT_W-1:0]   k_next;
  logic [STAGE_W-1:0] p_next;
  logic               r4_last;

  logic ren_d;
  logic en_d;
  logic wen_d;
  logic sel_d;
  logic drain;
  logic en_next;
  logic wen_next;

  logic wen_r2_tap;
  logic wen_r4_tap;
  logic en_r2_tap;
  logic en_r4_tap;

  assign conf_in = decode_conf(conf);

  // The final radix-4 stage ends after its first group completes (k=0, j=63).
  assign r4_last = (p == P_LAST_R4) && (k == 7'd0) && (j == 7'd63);

  // Command register and index counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_state <= CONF_IDLE;
      i          <= 7'd0;
      j          <= 7'd0;
      k          <= 7'd0;
      p          <= P_FIRST_R4;
    end else begin
      conf_state <= conf_in;
      i          <= i_next;
      j          <= j_next;
      k          <= k_next;
      p          <= p_next;
    end
  end

  // Next-state counter logic driven by the registered command.
  always_comb begin
    i_next = i;
    j_next = j;
    k_next = k;
    p_next = p;
    case (conf_state)
      CONF_RADIX4: begin
        // j innermost, then k, then p; i is left alone for the radix-2 mode.
        if (p > P_LAST_R4) begin
          // Entered straight from radix-2 with p=4: restart the sweep.
          j_next = 7'd0;
          k_next = 7'd0;
          p_next = P_FIRST_R4;
        end else if (r4_last) begin
          j_next = 7'd0;
          k_next = 7'd0;
          p_next = P_FIRST_R4;
        end else if (j == j_last(p)) begin
          j_next = 7'd0;
          if (k == k_last(p)) begin
            k_next = 7'd0;
            p_next = p + 3'd1;
          end else begin
            k_next = k + 7'd1;
          end
        end else begin
          j_next = j + 7'd1;
        end
      end
      CONF_RADIX2: begin
        // j and k are held so a radix-4 sweep is not disturbed.
        p_next = P_RADIX2;
        if (i == 7'd127) begin
          i_next = 7'd0;
        end else begin
          i_next = i + 7'd1;
        end
      end
      default: begin
        // Park the counters; preload p=4 so it is ready when radix-2 begins.
        i_next = 7'd0;
        j_next = 7'd0;
        k_next = 7'd0;
        if (conf_in == CONF_RADIX2) begin
          p_next = P_RADIX2;
        end else begin
          p_next = P_FIRST_R4;
        end
      end
    endcase
  end

  // Completion code, valid for the single cycle carrying the last butterfly.
  always_comb begin
    done_flag = DONE_NONE;
    case (conf_state)
      CONF_RADIX4: begin
        if (r4_last) begin
          done_flag = DONE_RADIX4;
        end else begin
          done_flag = DONE_NONE;
        end
      end
      CONF_RADIX2: begin
        if (i == 7'd127) begin
          done_flag = DONE_RADIX2;
        end else begin
          done_flag = DONE_NONE;
        end
      end
      default: done_flag = DONE_NONE;
    endcase
  end

  // Strobe decode from the registered command.
  always_comb begin
    ren_d = 1'b0;
    en_d  = 1'b0;
    wen_d = 1'b0;
    sel_d = 1'b0;
    drain = 1'b0;
    case (conf_state)
      CONF_RADIX4: begin
        ren_d = 1'b1;
        en_d  = 1'b1;
        wen_d = 1'b1;
        sel_d = 1'b1;
      end
      CONF_RADIX2: begin
        ren_d = 1'b1;
        en_d  = 1'b1;
        wen_d = 1'b1;
      end
      CONF_DONE_RADIX4: begin
        sel_d = 1'b1;
        drain = 1'b1;
      end
      CONF_DONE_RADIX2: begin
        drain = 1'b1;
      end
      default: begin
        drain = 1'b0;
      end
    endcase
  end

  // Write-enable pipelines, one per butterfly latency.
  delay_line #(.DEPTH(LAT_R2), .WIDTH(1)) u_wen_r2 (
    .clk (clk),
    .rst (rst),
    .d   (wen_d),
    .q   (wen_r2_tap)
  );

  delay_line #(.DEPTH(LAT_R4), .WIDTH(1)) u_wen_r4 (
    .clk (clk),
    .rst (rst),
    .d   (wen_d),
    .q   (wen_r4_tap)
  );

  // Enable pipelines one shorter, so that with the output register en keeps
  // the butterflies clocked until the last result is written back.
  delay_line #(.DEPTH(LAT_R2 - 1), .WIDTH(1)) u_en_r2 (
    .clk (clk),
    .rst (rst),
    .d   (en_d),
    .q   (en_r2_tap)
  );

  delay_line #(.DEPTH(LAT_R4 - 1), .WIDTH(1)) u_en_r4 (
    .clk (clk),
    .rst (rst),
    .d   (en_d),
    .q   (en_r4_tap)
  );

  // Pick the enable source (drain tap or live decode) and the write tap by path.
  always_comb begin
    en_next  = en_d;
    wen_next = wen_r2_tap;
    if (drain) begin
      if (sel) begin
        en_next = en_r4_tap;
      end else begin
        en_next = en_r2_tap;
      end
    end else begin
      en_next = en_d;
    end
    if (sel) begin
      wen_next = wen_r4_tap;
    end else begin
      wen_next = wen_r2_tap;
    end
  end

  // Registered strobe outputs; scale mirrors en whenever the radix-2 path is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel   <= 1'b0;
      ren   <= 1'b0;
      en    <= 1'b0;
      wen   <= 1'b0;
      scale <= 1'b0;
    end else begin
      sel   <= sel_d;
      ren   <= ren_d;
      en    <= en_next;
      wen   <= wen_next;
      scale <= en_next & ~sel_d;
    end
  end

endmodule

// File: tb/tb_intt_fsm.sv
// Directed self-checking bench for intt_fsm.
module tb_intt_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] conf;
  logic       sel;
  logic [6:0] i;
  logic [6:0] k;
  logic [6:0] j;
  logic [2:0] p;
  logic       ren;
  logic       en;
  logic       wen;
  logic       scale;
  logic [2:0] done_flag;

  int n_cmp = 0;
  int n_bad = 0;

  int done_cnt;
  int done_slot;
  int first_ren;
  int first_wen;
  int last_ren;
  int last_en;
  int last_wen;
  int last_scale;
  int sel_bad;
  int p_bad;
  int scale_bad;
  int idle_bad;

  intt_fsm #(.LAT_R2(8), .LAT_R4(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .conf      (conf),
    .sel       (sel),
    .i         (i),
    .k         (k),
    .j         (j),
    .p         (p),
    .ren       (ren),
    .en        (en),
    .wen       (wen),
    .scale     (scale),
    .done_flag (done_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {sel, ren, en, wen, scale, done_flag, i, j, k, p};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    rst  = 1'b1;
    conf = 4'b0000;
    tick(); tick(); tick();
    chk("reset_init", all_outs(), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", all_outs(), 32'd0);

    // Radix-4 sweep, conf held for 515 cycles.
    conf = 4'b0101;
    done_cnt = 0; done_slot = 0; first_ren = 0; first_wen = 0; sel_bad = 0;
    for (int n = 1; n <= 515; n++) begin
      tick();
      if (done_flag == 3'b011) begin done_cnt++; done_slot = n; end
      if (ren === 1'b1 && first_ren == 0) first_ren = n;
      if (wen === 1'b1 && first_wen == 0) first_wen = n;
      if (n >= 2 && sel !== 1'b1) sel_bad++;
      case (n)
        1:   chk("r4_c1",   {p, k, j}, {3'd0, 7'd0,   7'd0});
        2:   chk("r4_c2",   {p, k, j}, {3'd0, 7'd1,   7'd0});
        128: chk("r4_c128", {p, k, j}, {3'd0, 7'd127, 7'd0});
        129: chk("r4_c129", {p, k, j}, {3'd1, 7'd0,   7'd0});
        130: chk("r4_c130", {p, k, j}, {3'd1, 7'd0,   7'd1});
        133: chk("r4_c133", {p, k, j}, {3'd1, 7'd1,   7'd0});
        256: chk("r4_c256", {p, k, j}, {3'd1, 7'd31,  7'd3});
        257: chk("r4_c257", {p, k, j}, {3'd2, 7'd0,   7'd0});
        272: chk("r4_c272", {p, k, j}, {3'd2, 7'd0,   7'd15});
        273: chk("r4_c273", {p, k, j}, {3'd2, 7'd1,   7'd0});
        385: chk("r4_c385", {p, k, j}, {3'd3, 7'd0,   7'd0});
        448: chk("r4_last", {p, k, j, done_flag}, {3'd3, 7'd0, 7'd63, 3'b011});
        449: chk("r4_wrap", {p, k, j, done_flag}, {3'd0, 7'd0, 7'd0, 3'b000});
        450: chk("r4_c450", {p, k, j}, {3'd0, 7'd1,   7'd0});
        default: ;
      endcase
    end
    chk("r4_done_count", done_cnt, 32'd1);
    chk("r4_done_slot", done_slot, 32'd448);
    chk("r4_first_ren", first_ren, 32'd2);
    chk("r4_first_wen", first_wen, 32'd16);
    chk("r4_sel_high", sel_bad, 32'd0);

    // Drain after radix-4.
    conf = 4'b1000;
    last_ren = 0; last_en = 0; last_wen = 0;
    for (int d = 1; d <= 20; d++) begin
      tick();
      if (ren === 1'b1) last_ren = d;
      if (en === 1'b1) last_en = d;
      if (wen === 1'b1) last_wen = d;
      if (d == 3) chk("drain4_counters", {p, k, j, done_flag}, 32'd0);
      if (d == 5) chk("drain4_sel_scale", {sel, scale}, {1'b1, 1'b0});
    end
    chk("drain4_last_ren", last_ren, 32'd1);
    chk("drain4_last_en", last_en, 32'd14);
    chk("drain4_last_wen", last_wen, 32'd15);

    conf = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("idle_after_r4", all_outs(), 32'd0);

    // Radix-2 sweep, conf held for 130 cycles.
    conf = 4'b0110;
    done_cnt = 0; done_slot = 0; first_ren = 0; first_wen = 0;
    sel_bad = 0; p_bad = 0; scale_bad = 0;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (done_flag == 3'b100) begin done_cnt++; done_slot = n; end
      if (ren === 1'b1 && first_ren == 0) first_ren = n;
      if (wen === 1'b1 && first_wen == 0) first_wen = n;
      if (sel !== 1'b0) sel_bad++;
      if (p !== 3'd4) p_bad++;
      if (scale !== en) scale_bad++;
      case (n)
        1:   chk("r2_c1",   {p, i}, {3'd4, 7'd0});
        2:   chk("r2_c2",   {p, i}, {3'd4, 7'd1});
        128: chk("r2_last", {i, done_flag}, {7'd127, 3'b100});
        129: chk("r2_wrap", {i, done_flag}, {7'd0, 3'b000});
        130: chk("r2_c130", {p, i}, {3'd4, 7'd1});
        default: ;
      endcase
    end
    chk("r2_done_count", done_cnt, 32'd1);
    chk("r2_done_slot", done_slot, 32'd128);
    chk("r2_first_ren", first_ren, 32'd2);
    chk("r2_first_wen", first_wen, 32'd10);
    chk("r2_sel_low", sel_bad, 32'd0);
    chk("r2_p_four", p_bad, 32'd0);
    chk("r2_scale_tracks_en", scale_bad, 32'd0);

    // Drain after radix-2.
    conf = 4'b0111;
    last_ren = 0; last_en = 0; last_wen = 0; last_scale = 0; scale_bad = 0;
    for (int d = 1; d <= 14; d++) begin
      tick();
      if (ren === 1'b1) last_ren = d;
      if (en === 1'b1) last_en = d;
      if (wen === 1'b1) last_wen = d;
      if (scale === 1'b1) last_scale = d;
      if (scale !== en) scale_bad++;
    end
    chk("drain2_last_ren", last_ren, 32'd1);
    chk("drain2_last_en", last_en, 32'd8);
    chk("drain2_last_wen", last_wen, 32'd9);
    chk("drain2_last_scale", last_scale, 32'd8);
    chk("drain2_scale_tracks_en", scale_bad, 32'd0);

    conf = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("idle_after_r2", all_outs(), 32'd0);

    // Abort a radix-4 sweep at p=1, k=5.
    conf = 4'b0101;
    for (int n = 1; n <= 149; n++) begin
      tick();
    end
    chk("abort_point", {p, k, j}, {3'd1, 7'd5, 7'd0});
    conf = 4'b0000;
    tick(); tick();
    chk("abort_cleared", {p, k, j, done_flag}, 32'd0);
    for (int n = 1; n <= 20; n++) begin
      tick();
    end
    conf = 4'b0101;
    tick();
    chk("restart_c1", {p, k, j}, {3'd0, 7'd0, 7'd0});
    tick();
    chk("restart_c2", {p, k, j}, {3'd0, 7'd1, 7'd0});
    for (int n = 1; n <= 10; n++) begin
      tick();
    end

    // Reset for three cycles in the middle of the restarted sweep.
    rst = 1'b1;
    tick();
    chk("rst_mid_first", all_outs(), 32'd0);
    tick();
    conf = 4'b0000;
    tick();
    chk("rst_mid_third", all_outs(), 32'd0);
    rst = 1'b0;
    idle_bad = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (all_outs() !== 32'd0) idle_bad++;
    end
    chk("idle_after_mid_rst", idle_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
